simd_mem_requester: RTL

- Core-side initiator for the shared data-memory arbiter that serves `ncores` SIMD lanes through one 8-bit single-port RAM.
- Takes one vector load/store command from the control unit, latches per-lane byte addresses and write data, and raises per-lane `rden`/`wren`.
- For each lane it waits for that lane's `acq` grant, holds the request long enough for the RAM round trip, captures the lane's read byte from `Dq`, then pulses `done`.
- Sits between the control unit/register file and the arbiter.

---
 rtl/simd_mem_requester.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/simd_mem_requester.sv
// Vector load/store initiator toward the shared data-memory arbiter.
// Optional `define TIMEOUT_EN adds per-lane grant-wait timeouts (err).
module simd_mem_requester #(
  parameter int ncores      = 3,
  parameter int HOLD_CYC    = 3,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                op_write,
  input  logic [ncores-1:0]   lane_en,
  input  logic [8*ncores-1:0] addr_in,
  input  logic [8*ncores-1:0] wdata_in,
  output logic [ncores-1:0]   rden,
  output logic [ncores-1:0]   wren,
  output logic [8*ncores-1:0] Address,
  output logic [8*ncores-1:0] Din,
  input  logic [ncores-1:0]   acq,
  input  logic [8*ncores-1:0] Dq,
  output logic [8*ncores-1:0] rdata,
  output logic                busy,
  output logic                done,
  output logic [ncores-1:0]   err
);
  localparam int W  = 8 * ncores;
  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam logic [HW-1:0] HLAST = HW'(HOLD_CYC - 1);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, FIN} st_t;

  st_t             st_q   [ncores];
  st_t             st_d   [ncores];
  logic [HW-1:0]   hcnt_q [ncores];
  logic [HW-1:0]   hcnt_d [ncores];
  logic            op_q, op_d;
  logic [ncores-1:0] en_q, en_d;
  logic [W-1:0]    addr_q, addr_d;
  logic [W-1:0]    din_q, din_d;
  logic [W-1:0]    rdata_q, rdata_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            accept, all_fin;

`ifdef TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0]     tcnt_q [ncores];
  logic [TW-1:0]     tcnt_d [ncores];
  logic [ncores-1:0] err_q, err_d;
`endif

  assign accept = start & ~busy_q;

  always_comb begin
    all_fin = busy_q;
    for (int i = 0; i < ncores; i++) begin
      if (en_q[i] && st_q[i] != FIN) all_fin = 1'b0;
    end
  end

  always_comb begin
    op_d    = op_q;
    en_d    = en_q;
    addr_d  = addr_q;
    din_d   = din_q;
    rdata_d = rdata_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef TIMEOUT_EN
    err_d   = accept ? '0 : err_q;
`endif
    if (accept) begin
      op_d   = op_write;
      en_d   = lane_en;
      addr_d = addr_in;
      din_d  = wdata_in;
      busy_d = |lane_en;
      done_d = ~|lane_en;
    end
    if (all_fin) begin
      busy_d = 1'b0;
      done_d = 1'b1;
    end
    for (int i = 0; i < ncores; i++) begin
      st_d[i]   = st_q[i];
      hcnt_d[i] = hcnt_q[i];
`ifdef TIMEOUT_EN
      tcnt_d[i] = tcnt_q[i];
`endif
      unique case (st_q[i])
        IDLE: begin
          if (accept && lane_en[i]) begin
            st_d[i] = REQ;
`ifdef TIMEOUT_EN
            tcnt_d[i] = '0;
`endif
          end
        end
        REQ: begin
          if (acq[i]) begin
            st_d[i]   = HOLD;
            hcnt_d[i] = '0;
`ifdef TIMEOUT_EN
            tcnt_d[i] = '0;
          end else if (tcnt_q[i] == TLAST) begin
            st_d[i]  = FIN;
            err_d[i] = 1'b1;
          end else begin
            tcnt_d[i] = tcnt_q[i] + 1'b1;
`endif
          end
        end
        HOLD: begin
          // Losing the grant mid-hold means the RAM data is not ours yet.
          if (!acq[i]) begin
            st_d[i]   = REQ;
            hcnt_d[i] = '0;
          end else if (hcnt_q[i] == HLAST) begin
            st_d[i] = FIN;
            if (!op_q) rdata_d[8*i +: 8] = Dq[8*i +: 8];
          end else begin
            hcnt_d[i] = hcnt_q[i] + 1'b1;
          end
        end
        FIN: begin
          if (all_fin) st_d[i] = IDLE;
        end
        default: st_d[i] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= 1'b0;
      en_q    <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < ncores; i++) begin
        st_q[i]   <= IDLE;
        hcnt_q[i] <= '0;
      end
    end else begin
      op_q    <= op_d;
      en_q    <= en_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      for (int i = 0; i < ncores; i++) begin
        st_q[i]   <= st_d[i];
        hcnt_q[i] <= hcnt_d[i];
      end
    end
  end

`ifdef TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= '0;
      for (int i = 0; i < ncores; i++) tcnt_q[i] <= '0;
    end else begin
      err_q <= err_d;
      for (int i = 0; i < ncores; i++) tcnt_q[i] <= tcnt_d[i];
    end
  end
  assign err = err_q;
`else
  assign err = '0;
`endif

  always_comb begin
    rden = '0;
    wren = '0;
    for (int i = 0; i < ncores; i++) begin
      if (st_q[i] == REQ || st_q[i] == HOLD) begin
        rden[i] = ~op_q;
        wren[i] = op_q;
      end
    end
  end

  assign Address = addr_q;
  assign Din     = din_q;
  assign rdata   = rdata_q;
  assign busy    = busy_q;
  assign done    = done_q;
endmodule
